multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the fetch/decode datapath (PC register, PC+4 incrementer, instruction ROM, field decoder). It walks each instruction through FETCH → DECODE → EXEC → MEM → WB, generating PC/IR/register-file/ALU/data-memory controls from the latched instruction word. It runs a req/ack handshake with data memory, with a timeout. Illegal encodings and memory timeouts send it into a sticky trap state.

---
 rtl/multicycle_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the fetch/decode datapath.
// Generates PC/IR/RF/ALU/data-memory controls from the latched instruction word.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        ir_we,
  output logic        rf_we,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        mem_req,
  output logic        mem_we,
  output logic        wb_sel,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic        retired,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SRL = 4'd3,
                         ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_SLT = 4'd7;
  localparam logic [8:0] TMO_LIM = 9'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] cnt_q;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f3_ok, is_opimm, is_op, is_load, is_store, is_branch, is_nop, is_legal;
  logic [3:0] alu_fn;

  assign opcode    = instr[6:0];
  assign f3        = instr[14:12];
  assign f7        = instr[31:25];
  assign f3_ok     = (f3 != 3'b011) && ((f3 != 3'b101) || (f7 == 7'd0));
  assign is_opimm  = (opcode == 7'b0010011) && f3_ok;
  assign is_op     = (opcode == 7'b0110011) && f3_ok;
  assign is_load   = (opcode == 7'b0000011) && (f3 == 3'b010);
  assign is_store  = (opcode == 7'b0100011) && (f3 == 3'b010);
  assign is_branch = (opcode == 7'b1100011) && (f3[2:1] == 2'b00);
  assign is_nop    = (instr == 32'd0);
  assign is_legal  = is_opimm || is_op || is_load || is_store || is_branch;

  // funct7[5] only means SUB for register-register ADD; OP-IMM 000 is always ADD.
  always_comb begin
    alu_fn = ALU_ADD;
    case (f3)
      3'b000:  alu_fn = (is_op && f7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  // Memory handshake: mem_req is held for every MEM cycle; the cycle in which
  // mem_ack is high completes the access, and mem_req drops on the next cycle.
  always_comb begin
    state_d     = state_q;
    tmo_d       = 8'd0;
    cause_d     = cause_q;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    wb_sel      = 1'b0;
    retired     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we = run & rst;
        if (run) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_nop) begin
          pc_we   = 1'b1;
          retired = 1'b1;
          state_d = S_FETCH;
        end else if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          cause_d = 2'b01;
          state_d = S_TRAP;
        end
      end
      S_EXEC: begin
        if (is_opimm || is_op) begin
          alu_op      = alu_fn;
          alu_src_imm = is_opimm;
          state_d     = S_WB;
        end else if (is_load || is_store) begin
          alu_src_imm = 1'b1;
          state_d     = S_MEM;
        end else if (is_branch) begin
          alu_op  = ALU_SUB;
          pc_we   = 1'b1;
          retired = 1'b1;
          pc_sel  = f3[0] ? ~alu_zero : alu_zero;
          state_d = S_FETCH;
        end else begin
          cause_d = 2'b01;
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        mem_req     = 1'b1;
        mem_we      = is_store;
        alu_src_imm = 1'b1;
        if (mem_ack) begin
          if (is_store) begin
            pc_we   = 1'b1;
            retired = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (({1'b0, tmo_q} + 9'd1) >= TMO_LIM) begin
          cause_d = 2'b10;
          state_d = S_TRAP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        wb_sel  = is_load;
        pc_we   = 1'b1;
        retired = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      tmo_q   <= 8'd0;
      cause_q <= 2'b00;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cause_q <= cause_d;
      if (retired) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign state       = state_q;
  assign trap        = (state_q == S_TRAP);
  assign trap_cause  = cause_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors are
// queued by the driver and popped/compared by a negedge monitor.
module tb_multicycle_ctrl;
  localparam int W = 35;
  localparam logic [31:0] ADDI = 32'h00f00193, SW   = 32'h06502223, BEQ  = 32'h00518863,
                          LW   = 32'h05d22183, ILL  = 32'hFFFFFFFF, NOP  = 32'h00000000,
                          SUB  = 32'h403100B3, XORR = 32'h0020C0B3, SLTI = 32'h0050A093,
                          SRAI = 32'h4010D093;

  logic        clk = 1'b0;
  logic        rst = 1'b1, run = 1'b0, alu_zero = 1'b0, mem_ack = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        pc_we, pc_sel, ir_we, rf_we, alu_src_imm, mem_req, mem_we, wb_sel, trap, retired;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [1:0]  trap_cause;
  logic [15:0] instr_count;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .alu_zero(alu_zero), .mem_ack(mem_ack),
    .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .rf_we(rf_we), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .mem_req(mem_req), .mem_we(mem_we), .wb_sel(wb_sel),
    .state(state), .trap(trap), .trap_cause(trap_cause), .retired(retired),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_chk = 0, n_pass = 0;
  logic [15:0]  cnt = 16'd0;

  function automatic logic [W-1:0] ev(input logic [2:0] st, input logic pcwe, pcsel, irwe, rfwe,
                                      input logic [3:0] op, input logic imm, req, we, wbs, trp,
                                      input logic [1:0] cause, input logic ret);
    return {st, pcwe, pcsel, irwe, rfwe, op, imm, req, we, wbs, trp, cause, ret, cnt};
  endfunction

  function automatic logic [W-1:0] e_zero();             return ev(3'd0,0,0,0,0,4'd0,0,0,0,0,0,2'd0,0); endfunction
  function automatic logic [W-1:0] e_fetch(input logic i); return ev(3'd0,0,0,i,0,4'd0,0,0,0,0,0,2'd0,0); endfunction
  function automatic logic [W-1:0] e_dec();              return ev(3'd1,0,0,0,0,4'd0,0,0,0,0,0,2'd0,0); endfunction
  function automatic logic [W-1:0] e_nop();              return ev(3'd1,1,0,0,0,4'd0,0,0,0,0,0,2'd0,1); endfunction
  function automatic logic [W-1:0] e_exec(input logic [3:0] op, input logic imm);
    return ev(3'd2,0,0,0,0,op,imm,0,0,0,0,2'd0,0);
  endfunction
  function automatic logic [W-1:0] e_br(input logic sel);  return ev(3'd2,1,sel,0,0,4'd1,0,0,0,0,0,2'd0,1); endfunction
  function automatic logic [W-1:0] e_mem(input logic we, done);
    return ev(3'd3,done,0,0,0,4'd0,1,1,we,0,0,2'd0,done);
  endfunction
  function automatic logic [W-1:0] e_wb(input logic wbs);  return ev(3'd4,1,0,0,1,4'd0,0,0,0,wbs,0,2'd0,1); endfunction
  function automatic logic [W-1:0] e_trap(input logic [1:0] c); return ev(3'd7,0,0,0,0,4'd0,0,0,0,0,1,c,0); endfunction

  task automatic cyc(input logic r, rn, input logic [31:0] ir, input logic z, a,
                     input logic [W-1:0] e, input string t);
    @(posedge clk);
    #1;
    rst = r; run = rn; instr = ir; alu_zero = z; mem_ack = a;
    exp_q.push_back(e);
    tag_q.push_back(t);
    if (e[16]) cnt = cnt + 16'd1;
  endtask

  task automatic do_reset(input logic [31:0] ir);
    cnt = 16'd0;
    cyc(0, 1, ir, 1, 1, e_zero(), "reset_outputs");
    cyc(0, 1, ir, 1, 1, e_zero(), "reset_held");
  endtask

  task automatic alu_instr(input logic [31:0] ir, input logic [3:0] op, input logic imm, input string t);
    cyc(1, 1, ir, 0, 0, e_fetch(1), {t, "_fetch"});
    cyc(1, 1, ir, 0, 0, e_dec(), {t, "_decode"});
    cyc(1, 1, ir, 0, 0, e_exec(op, imm), {t, "_exec"});
    cyc(1, 1, ir, 0, 0, e_wb(0), {t, "_wb"});
  endtask

  always @(negedge clk) begin : monitor
    logic [W-1:0] got, e;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      got = {state, pc_we, pc_sel, ir_we, rf_we, alu_op, alu_src_imm, mem_req, mem_we,
             wb_sel, trap, trap_cause, retired, instr_count};
      n_chk++;
      if (got === e) n_pass++;
      else $display("FAIL %s: got %h required %h", t, got, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(ADDI);
    alu_instr(ADDI, 4'd0, 1, "addi");

    cyc(1, 1, SW, 0, 0, e_fetch(1), "sw_fetch");
    cyc(1, 1, SW, 0, 0, e_dec(), "sw_decode");
    cyc(1, 1, SW, 0, 0, e_exec(4'd0, 1), "sw_exec");
    cyc(1, 1, SW, 0, 0, e_mem(1, 0), "sw_mem1");
    cyc(1, 1, SW, 0, 0, e_mem(1, 0), "sw_mem2");
    cyc(1, 1, SW, 0, 1, e_mem(1, 1), "sw_mem_ack");

    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, BEQ, k == 0, 0, e_fetch(1), "beq_fetch");
      cyc(1, 1, BEQ, k == 0, 0, e_dec(), "beq_decode");
      cyc(1, 1, BEQ, k == 0, 0, e_br(k == 0), "beq_exec");
    end

    cyc(1, 1, LW, 0, 0, e_fetch(1), "lw_fetch");
    cyc(1, 1, LW, 0, 0, e_dec(), "lw_decode");
    cyc(1, 1, LW, 0, 0, e_exec(4'd0, 1), "lw_exec");
    for (int i = 0; i < 14; i++) cyc(1, 1, LW, 0, 0, e_mem(0, 0), "lw_mem_wait");
    cyc(1, 1, LW, 0, 1, e_mem(0, 0), "lw_mem_ack15");
    cyc(1, 1, LW, 0, 0, e_wb(1), "lw_wb");

    for (int i = 0; i < 5; i++) cyc(1, 0, NOP, 0, 0, e_fetch(0), "run_low_hold");
    cyc(1, 1, NOP, 0, 0, e_fetch(1), "nop_fetch");
    cyc(1, 1, NOP, 0, 0, e_nop(), "nop_decode");

    alu_instr(SUB, 4'd1, 0, "sub");
    alu_instr(XORR, 4'd6, 0, "xor");
    alu_instr(SLTI, 4'd7, 1, "slti");

    cyc(1, 1, LW, 0, 0, e_fetch(1), "lwto_fetch");
    cyc(1, 1, LW, 0, 0, e_dec(), "lwto_decode");
    cyc(1, 1, LW, 0, 0, e_exec(4'd0, 1), "lwto_exec");
    for (int i = 0; i < 15; i++) cyc(1, 1, LW, 0, 0, e_mem(0, 0), "lwto_mem_wait");
    for (int i = 0; i < 3; i++) cyc(1, i[0], LW, 0, ~i[0], e_trap(2'b10), "lwto_trap");
    do_reset(ILL);

    cyc(1, 1, ILL, 0, 0, e_fetch(1), "ill_fetch");
    cyc(1, 1, ILL, 0, 0, e_dec(), "ill_decode");
    for (int i = 0; i < 3; i++) cyc(1, i[0], ILL, 1, 1, e_trap(2'b01), "ill_trap");
    do_reset(SRAI);

    cyc(1, 1, SRAI, 0, 0, e_fetch(1), "srai_fetch");
    cyc(1, 1, SRAI, 0, 0, e_dec(), "srai_decode");
    cyc(1, 1, SRAI, 0, 0, e_trap(2'b01), "srai_trap");
    do_reset(SW);

    alu_instr(ADDI, 4'd0, 1, "addi2");
    cyc(1, 1, SW, 0, 0, e_fetch(1), "swrst_fetch");
    cyc(1, 1, SW, 0, 0, e_dec(), "swrst_decode");
    cyc(1, 1, SW, 0, 0, e_exec(4'd0, 1), "swrst_exec");
    cyc(1, 1, SW, 0, 0, e_mem(1, 0), "swrst_mem");
    do_reset(ADDI);
    alu_instr(ADDI, 4'd0, 1, "addi3");
    cyc(1, 0, ADDI, 0, 0, e_fetch(0), "final_fetch");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
